// File: rtl/uvme_cvmcu_obi_arb.sv
// Round-robin arbiter that muxes NUM_REQ OBI requesters onto one downstream OBI port.
// The address phase passes through combinationally. An ID FIFO routes the in-order responses back to their requesters.
module uvme_cvmcu_obi_arb #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            up_req,
  input  logic [NUM_REQ*ADDR_W-1:0]     up_addr,
  input  logic [NUM_REQ-1:0]            up_we,
  input  logic [NUM_REQ*(DATA_W/8)-1:0] up_be,
  input  logic [NUM_REQ*DATA_W-1:0]     up_wdata,
  output logic [NUM_REQ-1:0]            up_gnt,
  output logic [NUM_REQ-1:0]            up_rvalid,
  output logic [DATA_W-1:0]             up_rdata,
  output logic                          up_err,
  output logic                          dn_req,
  output logic [ADDR_W-1:0]             dn_addr,
  output logic                          dn_we,
  output logic [DATA_W/8-1:0]           dn_be,
  output logic [DATA_W-1:0]             dn_wdata,
  input  logic                          dn_gnt,
  input  logic                          dn_rvalid,
  input  logic [DATA_W-1:0]             dn_rdata,
  input  logic                          dn_err,
  output logic [$clog2(MAX_OUT):0]      outstanding,
  output logic                          orphan_err
);
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ARB, HOLD} state_t;

  state_t           state;
  logic [IDX_W-1:0] hold_idx;
  logic [IDX_W-1:0] prio;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] nxt_prio;
  logic [IDX_W-1:0] head;
  logic             rr_found;
  logic             sel_req;
  logic             full;
  logic             hs;
  logic             pop;
  logic [IDX_W-1:0] id_fifo [MAX_OUT];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;

  // The search starts at prio and wraps. The first asserted request in that order wins.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!rr_found && up_req[i] && ((int'(prio) + k) % NUM_REQ == i)) begin
          rr_found = 1'b1;
          rr_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign sel      = (state == HOLD) ? hold_idx : rr_idx;
  assign nxt_prio = (int'(sel) == NUM_REQ - 1) ? '0 : sel + IDX_W'(1);

  always_comb begin
    sel_req  = 1'b0;
    dn_addr  = '0;
    dn_we    = 1'b0;
    dn_be    = '0;
    dn_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IDX_W'(i)) begin
        sel_req  = up_req[i];
        dn_addr  = up_addr[i*ADDR_W +: ADDR_W];
        dn_we    = up_we[i];
        dn_be    = up_be[i*BE_W +: BE_W];
        dn_wdata = up_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // A slot freed by a pop this cycle only becomes usable on the next cycle.
  assign full   = (count == CNT_W'(MAX_OUT));
  assign dn_req = reset_n & sel_req & ~full;
  assign hs     = dn_req & dn_gnt;
  assign pop    = reset_n & dn_rvalid & (count != '0);
  assign head   = id_fifo[rptr];

  always_comb begin
    up_gnt    = '0;
    up_rvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      up_gnt[i]    = hs  && (sel  == IDX_W'(i));
      up_rvalid[i] = pop && (head == IDX_W'(i));
    end
  end

  assign up_rdata    = dn_rdata;
  assign up_err      = dn_err;
  assign outstanding = count;

  always_ff @(posedge clk) begin
    if (hs) id_fifo[wptr] <= sel;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ARB;
      hold_idx   <= '0;
      prio       <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      orphan_err <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (dn_req && !dn_gnt) begin
            state    <= HOLD;
            hold_idx <= sel;
          end
        end
        // If the held requester withdraws its request, the arbiter goes back to ARB without recording a transaction.
        HOLD: begin
          if (!sel_req || hs) state <= ARB;
        end
        default: state <= ARB;
      endcase
      if (hs) begin
        prio <= nxt_prio;
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) rptr <= rptr + PTR_W'(1);
      if (hs && !pop)      count <= count + CNT_W'(1);
      else if (!hs && pop) count <= count - CNT_W'(1);
      if (dn_rvalid && count == '0) orphan_err <= 1'b1;
    end
  end

endmodule
